// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard frame receiver with input sync, clock deglitch, parity/framing checks.
// Define PS2_TIMEOUT_EN to abort frames that stall for TIMEOUT_CYCLES clk cycles.
module ps2_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       i_sclr_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_en,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam int FW = $clog2(FILTER_LEN + 1);
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_q, cs_d, ds_q, ds_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic filt_q, filt_d, filt_prev_q, filt_prev_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d, byte_q, byte_d;
  logic par_q, par_d, byte_en_q, byte_en_d, perr_q, perr_d, ferr_q, ferr_d;
  logic fall, din, stable;
`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif
  always_comb begin
    cs_d        = {cs_q[SYNC_STAGES-2:0], i_ps2_clk};
    ds_d        = {ds_q[SYNC_STAGES-2:0], i_ps2_data};
    din         = ds_q[SYNC_STAGES-1];
    stable      = cs_q[SYNC_STAGES-1] == filt_q;
    fcnt_d      = stable ? '0 : fcnt_q + 1'b1;
    filt_d      = filt_q;
    filt_prev_d = filt_q;
    fall        = filt_prev_q & ~filt_q;
    // the filtered clock only flips after FILTER_LEN consecutive disagreeing samples
    if (!stable && fcnt_q == FW'(FILTER_LEN - 1)) begin
      filt_d = ~filt_q;
      fcnt_d = '0;
    end
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    byte_d    = byte_q;
    byte_en_d = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: if (!din) begin
          state_d  = DATA;
          bitcnt_d = '0;
          shift_d  = '0;
        end
        DATA: begin
          shift_d  = {din, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          state_d  = (bitcnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (!din) ferr_d = 1'b1;
          else if (!(^{shift_q, par_q})) perr_d = 1'b1;
          else begin
            byte_d    = shift_q;
            byte_en_d = 1'b1;
          end
        end
      endcase
    end
`ifdef PS2_TIMEOUT_EN
    tmo_d = (fall || state_q == IDLE) ? '0 : tmo_q + 1'b1;
    if (!fall && state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      shift_d  = '0;
      ferr_d   = 1'b1;
      tmo_d    = '0;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      cs_q        <= '1;
      ds_q        <= '1;
      fcnt_q      <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      byte_q      <= '0;
      byte_en_q   <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      cs_q        <= cs_d;
      ds_q        <= ds_d;
      fcnt_q      <= fcnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      byte_q      <= byte_d;
      byte_en_q   <= byte_en_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
`ifdef PS2_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end
  assign o_byte       = byte_q;
  assign o_byte_en    = byte_en_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = state_q != IDLE;
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: randomized PS/2 frames with a queue scoreboard checked by an independent monitor.
module tb_ps2_rx;
  logic clk = 1'b0, sclr_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] o_byte;
  logic o_byte_en, o_parity_err, o_frame_err, o_busy;
  always #5 clk = ~clk;
  ps2_rx dut (
    .clk(clk), .i_sclr_n(sclr_n), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .o_byte(o_byte), .o_byte_en(o_byte_en), .o_parity_err(o_parity_err),
    .o_frame_err(o_frame_err), .o_busy(o_busy)
  );
  // p: expected pulse vector {byte_en, parity_err, frame_err}; b: expected o_byte after the event
  typedef struct packed {logic [2:0] p; logic [7:0] b;} ev_t;
  ev_t exp_q[$];
  int tests = 0, fails = 0;
  logic [7:0] model_byte = 8'h00;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cyc(8);
    ps2_clk = 1'b0;
    cyc(20);
    ps2_clk = 1'b1;
    cyc(12);
  endtask
  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) ps2_bit(fr[i]);
  endtask
  task automatic push(input logic [2:0] p);
    ev_t e;
    e.p = p;
    e.b = model_byte;
    exp_q.push_back(e);
  endtask
  task automatic send(input logic [7:0] d, input logic par, input logic stop);
    if (!stop) push(3'b001);
    else if ($countones({d, par}) % 2 == 0) push(3'b010);
    else begin
      model_byte = d;
      push(3'b100);
    end
    send_bits({stop, par, d, 1'b0}, 11);
    ps2_data = 1'b1;
    cyc(10);
    chk("frame_drained", exp_q.size(), 0);
  endtask
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (o_byte_en | o_parity_err | o_frame_err) begin
        chk("single_pulse", $countones({o_byte_en, o_parity_err, o_frame_err}), 1);
        if (exp_q.size() == 0) chk("unexpected_pulse", {o_byte_en, o_parity_err, o_frame_err}, 0);
        else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {o_byte_en, o_parity_err, o_frame_err}, e.p);
          chk("o_byte", o_byte, e.b);
        end
      end
    end
  end
  initial begin
    logic [7:0] d;
    logic par, stop;
    cyc(3);
    chk("reset_busy", o_busy, 0);
    chk("reset_byte", o_byte, 0);
    chk("reset_pulses", {o_byte_en, o_parity_err, o_frame_err}, 0);
    sclr_n = 1'b1;
    cyc(5);
    send(8'h12, 1'b1, 1'b1);
    send(8'hF0, 1'b1, 1'b1);
    send(8'h12, 1'b1, 1'b1);
    send(8'h1C, 1'b1, 1'b1);
    chk("byte_held_after_perr", o_byte, 8'h12);
    send(8'h59, 1'b1, 1'b0);
    chk("byte_held_after_ferr", o_byte, 8'h12);
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    cyc(2);
    ps2_clk = 1'b1;
    cyc(20);
    chk("glitch_ignored", o_busy, 0);
    ps2_data = 1'b1;
    cyc(5);
    send_bits({1'b1, 1'b1, 8'h59, 1'b0}, 5);
    chk("busy_mid_frame", o_busy, 1);
    sclr_n = 1'b0;
    cyc(1);
    chk("busy_after_reset", o_busy, 0);
    chk("byte_after_reset", o_byte, 0);
    model_byte = 8'h00;
    sclr_n = 1'b1;
    cyc(5);
    send(8'h59, 1'b1, 1'b1);
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      par = ($countones(d) % 2 == 0) ^ ($urandom_range(0, 4) == 0);
      stop = $urandom_range(0, 9) != 0;
      send(d, par, stop);
    end
`ifdef PS2_TIMEOUT_EN
    send_bits({1'b1, 1'b1, 8'h12, 1'b0}, 4);
    ps2_data = 1'b1;
    push(3'b001);
    cyc(5050);
    chk("timeout_drained", exp_q.size(), 0);
    chk("timeout_idle", o_busy, 0);
    send(8'h12, 1'b1, 1'b1);
    chk("after_timeout_byte", o_byte, 8'h12);
`endif
    cyc(50);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
